placar_comando: RTL and testbench

- Per-team score command stage for the basketball scoreboard. It sits directly upstream of the 7-bit adder/subtractor, and also consumes that adder's result.
- Synchronizes and debounces the three point buttons (+1/+2/+3) and the add/subtract switch, then drives the adder's point operand and Cin.
- Holds the registered team score that feeds the adder's A input.
- Latches the adder's S/Cout back into the score, clamped to 0..MAX_SCORE, with a one-cycle update pulse for the display stage.

---
 rtl/placar_comando.sv | 114 +++++++++++
 tb/tb_placar_comando.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/placar_comando.sv
// placar_comando: debounced point-command stage that drives the score adder and
// latches its clamped result back into the team score.
module placar_comando #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int MAX_SCORE       = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_1,
    input  logic       btn_2,
    input  logic       btn_3,
    input  logic       sub_mode,
    input  logic       zerar,
    input  logic [6:0] soma_in,
    input  logic       cout_in,
    output logic [1:0] pontos,
    output logic       cin,
    output logic [6:0] placar,
    output logic       update,
    output logic       erro
);
    typedef enum logic [1:0] {IDLE, DEBOUNCE, APPLY, HOLD} state_t;
    localparam logic [6:0]       MAX7     = 7'(MAX_SCORE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    state_t           r_state, w_state_nxt;
    logic [2:0]       r_btn_m, r_btn_s;
    logic             r_sub_m, r_sub_s;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_pontos, w_pontos_nxt;
    logic             r_cin, w_cin_nxt;
    logic [6:0]       r_placar, w_placar_nxt;
    logic             r_update, w_update_nxt;
    logic             r_erro, w_erro_nxt;
    logic             w_one_hot, w_keep, w_clamp;
    logic [1:0]       w_pts;
    logic [2:0]       w_cap;
    logic [6:0]       w_result;
    assign w_one_hot = (r_btn_s == 3'b001) || (r_btn_s == 3'b010) || (r_btn_s == 3'b100);
    assign w_pts     = r_btn_s[0] ? 2'd1 : r_btn_s[1] ? 2'd2 : 2'd3;
    assign w_cap     = r_pontos == 2'd1 ? 3'b001 : r_pontos == 2'd2 ? 3'b010 : 3'b100;
    assign w_keep    = r_btn_s == w_cap;
    // Subtraction underflows when the adder produces no carry (a borrow occurred).
    assign w_clamp   = r_cin ? !cout_in : soma_in > MAX7;
    assign w_result  = w_clamp ? (r_cin ? 7'd0 : MAX7) : soma_in;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_btn_m  <= '0;
            r_btn_s  <= '0;
            r_sub_m  <= 1'b0;
            r_sub_s  <= 1'b0;
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_pontos <= '0;
            r_cin    <= 1'b0;
            r_placar <= '0;
            r_update <= 1'b0;
            r_erro   <= 1'b0;
        end else begin
            r_btn_m  <= {btn_3, btn_2, btn_1};
            r_btn_s  <= r_btn_m;
            r_sub_m  <= sub_mode;
            r_sub_s  <= r_sub_m;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pontos <= w_pontos_nxt;
            r_cin    <= w_cin_nxt;
            r_placar <= w_placar_nxt;
            r_update <= w_update_nxt;
            r_erro   <= w_erro_nxt;
        end
    end
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_pontos_nxt = r_pontos;
        w_cin_nxt    = r_cin;
        w_placar_nxt = r_placar;
        w_update_nxt = 1'b0;
        w_erro_nxt   = r_erro;
        case (r_state)
            IDLE: if (w_one_hot) begin
                w_pontos_nxt = w_pts;
                w_cin_nxt    = r_sub_s;
                w_cnt_nxt    = '0;
                w_state_nxt  = DEBOUNCE;
            end
            DEBOUNCE: begin
                w_state_nxt = !w_keep ? IDLE : r_cnt == CNT_LAST ? APPLY : DEBOUNCE;
                w_cnt_nxt   = (w_keep && r_cnt != CNT_LAST) ? r_cnt + 1'b1 : r_cnt;
            end
            APPLY: begin
                w_placar_nxt = w_result;
                w_erro_nxt   = w_clamp;
                w_update_nxt = 1'b1;
                w_state_nxt  = HOLD;
            end
            HOLD:    w_state_nxt = r_btn_s == 3'b000 ? IDLE : HOLD;
            default: w_state_nxt = IDLE;
        endcase
        if (zerar) begin
            w_placar_nxt = '0;
            w_erro_nxt   = 1'b0;
            w_update_nxt = 1'b0;
            w_cnt_nxt    = '0;
            w_state_nxt  = IDLE;
        end
    end
    assign pontos = r_pontos;
    assign cin    = r_cin;
    assign placar = r_placar;
    assign update = r_update;
    assign erro   = r_erro;
endmodule

// File: tb/tb_placar_comando.sv
// tb_placar_comando: randomized scoreboard bench for placar_comando with an
// external adder/subtractor model closing the score loop.
module tb_placar_comando;
    localparam int D   = 4;
    localparam int MAX = 99;
    typedef struct {
        int placar;
        int erro;
        int pontos;
        int cin;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_1 = 1'b0, btn_2 = 1'b0, btn_3 = 1'b0, sub_mode = 1'b0, zerar = 1'b0;
    logic [6:0] soma_in, placar;
    logic       cout_in, cin, update, erro;
    logic [1:0] pontos;
    logic [7:0] sum8;
    int         checks = 0, failures = 0;
    int         score = 0, err = 0;
    exp_t       q[$];
    always #5 clk = ~clk;
    // Adder/subtractor environment: B is inverted and Cin added when subtracting.
    assign sum8    = {1'b0, placar} + {1'b0, cin ? ~{5'd0, pontos} : {5'd0, pontos}} + {7'd0, cin};
    assign soma_in = sum8[6:0];
    assign cout_in = sum8[7];
    placar_comando #(.DEBOUNCE_CYCLES(D), .CNT_W(4), .MAX_SCORE(MAX)) dut (
        .clk(clk), .rst_n(rst_n), .btn_1(btn_1), .btn_2(btn_2), .btn_3(btn_3),
        .sub_mode(sub_mode), .zerar(zerar), .soma_in(soma_in), .cout_in(cout_in),
        .pontos(pontos), .cin(cin), .placar(placar), .update(update), .erro(erro)
    );
    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", n, a, e);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // A steady pattern long enough to survive debounce is exactly one scored command.
    task automatic press(input logic [2:0] p, input int len, input logic sub, input bit flip);
        int pts;
        if ($countones(p) == 1 && len >= D + 1) begin
            pts = p[0] ? 1 : p[1] ? 2 : 3;
            if (sub) begin
                if (score >= pts) begin score -= pts; err = 0; end
                else begin score = 0; err = 1; end
            end else if (score + pts > MAX) begin
                score = MAX; err = 1;
            end else begin
                score += pts; err = 0;
            end
            q.push_back(exp_t'{score, err, pts, int'(sub)});
        end
        for (int i = 0; i < len; i++) begin
            tick();
            {btn_3, btn_2, btn_1} = p;
            sub_mode = (flip && i > 0 && i % 2 == 1) ? ~sub : sub;
        end
    endtask
    task automatic gap(input int n, input bit clr);
        for (int i = 0; i < n; i++) begin
            tick();
            {btn_3, btn_2, btn_1} = 3'b000;
            zerar = clr && i == 4;
            if (clr && i == 4) begin score = 0; err = 0; end
        end
    endtask
    task automatic chk_score(input string n);
        chk({n, "_placar"}, int'(placar), score);
        chk({n, "_erro"}, int'(erro), err);
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            chk("placar_le_max", int'(placar <= 7'(MAX)), 1);
            if (update) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_update placar=%0d expected no update", placar);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("upd_placar", int'(placar), e.placar);
                    chk("upd_erro", int'(erro), e.erro);
                    chk("upd_pontos", int'(pontos), e.pontos);
                    chk("upd_cin", int'(cin), e.cin);
                end
            end
        end
    end
    initial begin
        logic [2:0] p;
        int         len, n;
        repeat (3) tick();
        chk("rst_placar", int'(placar), 0);
        chk("rst_pontos", int'(pontos), 0);
        chk("rst_cin", int'(cin), 0);
        chk("rst_update", int'(update), 0);
        chk("rst_erro", int'(erro), 0);
        rst_n = 1'b1;
        gap(3, 0);
        press(3'b010, 12, 0, 0); gap(4, 0);
        chk_score("basic");
        chk("basic_pontos", int'(pontos), 2);
        chk("basic_cin", int'(cin), 0);
        gap(8, 1);
        repeat (32) begin press(3'b100, 6, 0, 0); gap(2, 0); end
        press(3'b010, 6, 0, 0); gap(4, 0);
        chk("preload_98", int'(placar), 98);
        press(3'b100, 6, 0, 0); gap(4, 0);
        chk_score("clamp_hi");
        press(3'b001, 6, 0, 0); gap(4, 0);
        chk_score("clamp_hi_again");
        gap(8, 1);
        press(3'b100, 6, 0, 0); gap(2, 0);
        press(3'b010, 6, 0, 0); gap(4, 0);
        chk("preload_5", int'(placar), 5);
        press(3'b100, 8, 1, 1); gap(4, 0);
        chk_score("sub");
        chk("sub_cin", int'(cin), 1);
        press(3'b100, 8, 1, 0); gap(4, 0);
        chk_score("sub_underflow");
        press(3'b100, 6, 0, 0); gap(4, 0);
        press(3'b001, 2, 0, 0); gap(1, 0);
        press(3'b001, 2, 0, 0); gap(4, 0);
        chk_score("bounce");
        press(3'b001, 10, 0, 0); gap(4, 0);
        chk_score("steady");
        press(3'b011, 10, 0, 0); gap(4, 0);
        chk_score("dual_press");
        press(3'b010, 2, 0, 0);
        press(3'b110, 6, 0, 0); gap(4, 0);
        chk_score("abort");
        press(3'b100, 100, 0, 0); gap(4, 0);
        chk_score("long_hold");
        gap(8, 1);
        repeat (13) begin press(3'b100, 6, 0, 0); gap(2, 0); end
        press(3'b001, 6, 0, 0); gap(4, 0);
        chk("preload_40", int'(placar), 40);
        sub_mode = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            {btn_3, btn_2, btn_1} = 3'b010;
            zerar = i == 4;
            if (i == 5) begin
                chk("clr_placar", int'(placar), 0);
                chk("clr_update", int'(update), 0);
                chk("clr_pontos_hold", int'(pontos), 2);
                score = 2;
                err = 0;
                q.push_back(exp_t'{2, 0, 2, 0});
            end
        end
        gap(4, 0);
        chk_score("clr_reapply");
        repeat (80) begin
            p   = $urandom_range(0, 9) < 7 ? 3'(1 << $urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            len = $urandom_range(1, 12);
            n   = $urandom_range(2, 8);
            press(p, len, $urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)));
            gap(n, n >= 6 && $urandom_range(0, 4) == 0);
        end
        gap(6, 0);
        chk_score("final");
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
